adc_axis_tx: RTL and testbench

- AXI-Stream transmitter: the producer side of the 32-bit ADC sample stream that pdh_core consumes on S_AXIS_tdata_i/S_AXIS_tvalid_i.
- Captures both 14-bit ADC channels, sign-extends each to 16 bits, and packs them as {chB, chA}.
- Applies runtime decimation and buffers samples in a small FIFO so downstream backpressure never stalls capture.
- Reports overflow, i.e. samples dropped on a full FIFO.

---
 rtl/adc_axis_tx.sv | 169 ++++++++++++++++
 tb/tb_adc_axis_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_axis_tx.sv
// ============================================================================
// Module  : adc_axis_tx
// Purpose : Dual-channel ADC to AXI-Stream producer with decimation, a small
//           show-ahead FIFO and a saturating overflow counter. Optional
//           packet framing (M_AXIS_tlast_o) under ADC_AXIS_TX_TLAST_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_axis_tx #(
  parameter int ADC_WIDTH  = 14,
  parameter int LANE_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DEC_WIDTH  = 16,
  parameter int PKT_LEN    = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable_i,
  input  logic [DEC_WIDTH-1:0]            dec_i,
  input  logic [ADC_WIDTH-1:0]            adc_dat_a_i,
  input  logic [ADC_WIDTH-1:0]            adc_dat_b_i,
  output logic [2*LANE_WIDTH-1:0]         M_AXIS_tdata_o,
  output logic                            M_AXIS_tvalid_o,
  input  logic                            M_AXIS_tready_i,
`ifdef ADC_AXIS_TX_TLAST_EN
  output logic                            M_AXIS_tlast_o,
`endif
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic [15:0]                     ovf_cnt_o,
  input  logic                            ovf_clr_i
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;
  localparam int DW  = 2 * LANE_WIDTH;
  localparam int EXT = LANE_WIDTH - ADC_WIDTH;

  if ((FIFO_DEPTH < 2) || ((1 << PW) != FIFO_DEPTH) || (EXT < 1) || (PKT_LEN < 1))
  begin : g_param_check
    $error("adc_axis_tx: illegal parameter combination");
  end

  logic [DW-1:0]        cap_data_q, cap_data_d;
  logic                 cap_vld_q, cap_vld_d;
  logic [DEC_WIDTH-1:0] dcnt_q, dcnt_d;
  logic [DW-1:0]        mem_q [FIFO_DEPTH];
  logic [DW-1:0]        mem_d [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [15:0]          ovf_q, ovf_d;

  logic w_pop;
  logic w_full;
  logic w_accept;
  logic w_drop;

  // Capture stage: the push strobe travels alongside the sample it selects.
  always_comb begin
    cap_data_d = {{EXT{adc_dat_b_i[ADC_WIDTH-1]}}, adc_dat_b_i,
                  {EXT{adc_dat_a_i[ADC_WIDTH-1]}}, adc_dat_a_i};
    cap_vld_d  = enable_i && (dcnt_q == '0);
    dcnt_d     = '0;
    if (enable_i && (dcnt_q < dec_i)) begin
      dcnt_d = dcnt_q + DEC_WIDTH'(1);
    end
  end

  always_comb begin
    w_pop    = (level_q != '0) && M_AXIS_tready_i;
    w_full   = (level_q == LW'(FIFO_DEPTH));
    w_accept = cap_vld_q && (!w_full || w_pop);
    w_drop   = cap_vld_q && !w_accept;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_accept) begin
      mem_d[wr_ptr_q] = cap_data_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (w_accept && !w_pop) begin
      level_d = level_q + LW'(1);
    end else if (!w_accept && w_pop) begin
      level_d = level_q - LW'(1);
    end
  end

  // Clear has priority over a same-cycle drop.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr_i) begin
      ovf_d = '0;
    end else if (w_drop && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_data_q <= '0;
      cap_vld_q  <= 1'b0;
      dcnt_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cap_data_q <= cap_data_d;
      cap_vld_q  <= cap_vld_d;
      dcnt_q     <= dcnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      mem_q      <= mem_d;
    end
  end

  assign M_AXIS_tvalid_o = (level_q != '0);
  assign M_AXIS_tdata_o  = M_AXIS_tvalid_o ? mem_q[rd_ptr_q] : '0;
  assign fifo_level_o    = level_q;
  assign ovf_cnt_o       = ovf_q;

`ifdef ADC_AXIS_TX_TLAST_EN
  logic [15:0]          pkt_q, pkt_d;
  logic [FIFO_DEPTH-1:0] last_q, last_d;
  logic                 w_pkt_end;

  // Only accepted samples advance the packet position.
  always_comb begin
    w_pkt_end = (pkt_q == 16'(PKT_LEN - 1));
    pkt_d     = pkt_q;
    last_d    = last_q;
    if (w_accept) begin
      last_d[wr_ptr_q] = w_pkt_end;
      pkt_d            = w_pkt_end ? 16'd0 : pkt_q + 16'd1;
    end
    if (!enable_i) begin
      pkt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q  <= '0;
      last_q <= '0;
    end else begin
      pkt_q  <= pkt_d;
      last_q <= last_d;
    end
  end

  assign M_AXIS_tlast_o = M_AXIS_tvalid_o && last_q[rd_ptr_q];
`endif

endmodule

`default_nettype wire

// File: tb/tb_adc_axis_tx.sv
// Self-checking bench for adc_axis_tx: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
`default_nettype none

module tb_adc_axis_tx;

  localparam int PKT = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] dec = '0;
  logic [13:0] ra = '0;
  logic [13:0] rb = '0;
  logic        ready = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] tdata;
  logic        tvalid;
  logic [2:0]  level;
  logic [15:0] ovf;
`ifdef ADC_AXIS_TX_TLAST_EN
  logic        tlast;
`endif

  int errors = 0;
  int checks = 0;

  adc_axis_tx #(
    .ADC_WIDTH(14), .LANE_WIDTH(16), .FIFO_DEPTH(DEPTH), .DEC_WIDTH(16), .PKT_LEN(PKT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable_i(en),
    .dec_i(dec),
    .adc_dat_a_i(ra),
    .adc_dat_b_i(rb),
    .M_AXIS_tdata_o(tdata),
    .M_AXIS_tvalid_o(tvalid),
    .M_AXIS_tready_i(ready),
`ifdef ADC_AXIS_TX_TLAST_EN
    .M_AXIS_tlast_o(tlast),
`endif
    .fifo_level_o(level),
    .ovf_cnt_o(ovf),
    .ovf_clr_i(clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model state: expected FIFO contents as {tlast, tdata}.
  logic [32:0] mq[$];
  logic [31:0] pend_data;
  bit          pend_v;
  int          phase;
  int          m_ovf;
  int          pkt;
  logic [15:0] alog[$];
  logic        llog[$];

  function automatic logic [15:0] to_lane(input logic [13:0] raw);
    int v;
    v = int'(raw);
    if (v >= 8192) v = v - 16384;
    return 16'(v);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend_v = 0;
    pend_data = '0;
    phase = 0;
    m_ovf = 0;
    pkt = 0;
  endtask

  task automatic model_update();
    bit pop;
    bit lst;
    pop = (mq.size() != 0) && ready;
    if (pop) void'(mq.pop_front());
    if (pend_v) begin
      if (mq.size() < DEPTH) begin
        lst = (pkt == PKT - 1);
        mq.push_back({lst, pend_data});
        pkt = lst ? 0 : pkt + 1;
      end else if (!clr && m_ovf < 65535) begin
        m_ovf++;
      end
    end
    if (clr) m_ovf = 0;
    if (!en) pkt = 0;
    pend_v = en && (phase == 0);
    pend_data = {to_lane(rb), to_lane(ra)};
    if (!en || phase >= int'(dec)) phase = 0;
    else phase++;
  endtask

  task automatic compare_all();
    logic [32:0] head;
    head = (mq.size() != 0) ? mq[0] : 33'd0;
    chk("tvalid", 64'(tvalid), 64'(mq.size() != 0));
    chk("tdata", 64'(tdata), 64'(head[31:0]));
    chk("level", 64'(level), 64'(mq.size()));
    chk("ovf_cnt", 64'(ovf), 64'(m_ovf));
`ifdef ADC_AXIS_TX_TLAST_EN
    chk("tlast", 64'(tlast), 64'(head[32]));
    if (tvalid && ready) llog.push_back(tlast);
`endif
    if (tvalid && ready) alog.push_back(tdata[15:0]);
  endtask

  // One clock: inputs already set, model follows the edge, outputs checked at negedge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  // Called at a negedge; pulls reset between edges and checks outputs at once.
  task automatic do_async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int snap;
    int n;
    model_reset();
    @(negedge clk);
    do_async_reset();

    // Sign extension and two-cycle latency, one beat per cycle.
    en = 1; dec = 0; ready = 1; ra = 14'h1FFF; rb = 14'h2000;
    cycle();
    chk("lat_not_yet", 64'(tvalid), 64'd0);
    cycle();
    chk("lat_valid", 64'(tvalid), 64'd1);
    chk("sext_data", 64'(tdata), 64'h0000_0000_E000_1FFF);
    repeat (6) begin
      cycle();
      chk("level_le1", 64'(level <= 3'd1), 64'd1);
    end

    // Decimation by 4, then shortened to 2 while the counter sits at 2.
    en = 0;
    do_async_reset();
    alog.delete();
    en = 1; ready = 1;
    for (int k = 0; k <= 16; k++) begin
      ra = 14'(k); rb = 14'(100 + k);
      dec = (k >= 10) ? 16'd1 : 16'd3;
      cycle();
    end
    en = 0;
    repeat (3) cycle();
    chk("dec_count", 64'(alog.size()), 64'd6);
    if (alog.size() == 6) begin
      chk("dec_b0", 64'(alog[0]), 64'd0);
      chk("dec_b1", 64'(alog[1]), 64'd4);
      chk("dec_b2", 64'(alog[2]), 64'd8);
      chk("dec_b3", 64'(alog[3]), 64'd11);
      chk("dec_b4", 64'(alog[4]), 64'd13);
      chk("dec_b5", 64'(alog[5]), 64'd15);
    end

    // Backpressure: FIFO fills, later samples are dropped and counted.
    do_async_reset();
    en = 1; dec = 0; ready = 0;
    for (int k = 0; k < 10; k++) begin
      ra = 14'(200 + k); rb = 14'(k);
      cycle();
    end
    en = 0;
    cycle();
    chk("full_level", 64'(level), 64'd4);
    chk("full_head", 64'(tdata[15:0]), 64'd200);
    chk("ovf_six", 64'(ovf), 64'd6);
    en = 1;
    cycle();
    en = 0; clr = 1;
    cycle();
    clr = 0;
    chk("ovf_clr_wins", 64'(ovf), 64'd0);

    // Full FIFO with pop and push in the same cycle.
    en = 1; dec = 0; ready = 0;
    repeat (3) begin
      ra = 14'($urandom); rb = 14'($urandom);
      cycle();
    end
    snap = m_ovf;
    ready = 1;
    cycle();
    chk("fullpp_level", 64'(level), 64'd4);
    chk("fullpp_ovf", 64'(ovf), 64'(snap));
    en = 0;
    repeat (8) cycle();
    chk("drained", 64'(level), 64'd0);

    // Reset while three beats are queued.
    en = 1; dec = 0; ready = 0;
    n = 0;
    while (mq.size() < 3 && n < 10) begin
      ra = 14'($urandom); rb = 14'($urandom);
      cycle();
      n++;
    end
    chk("pre_reset_level", 64'(level), 64'd3);
    do_async_reset();
    en = 1; ready = 1; ra = 14'h00AB; rb = 14'h3FFF;
    cycle();
    cycle();
    chk("post_reset_beat", 64'(tdata), 64'h0000_0000_FFFF_00AB);

`ifdef ADC_AXIS_TX_TLAST_EN
    en = 0;
    do_async_reset();
    llog.delete();
    en = 1; dec = 0; ready = 1;
    repeat (14) begin
      ra = 14'($urandom); rb = 14'($urandom);
      cycle();
    end
    chk("tlast_count", 64'(llog.size() >= 12), 64'd1);
    if (llog.size() >= 12) begin
      for (int i = 0; i < 12; i++) begin
        chk("tlast_pos", 64'(llog[i]), 64'((i % 4) == 3));
      end
    end
    ready = 0;
    repeat (7) cycle();
    ready = 1;
    repeat (12) cycle();
`endif

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      en    = ($urandom_range(0, 9) != 0);
      dec   = 16'($urandom_range(0, 3));
      ready = ($urandom_range(0, 2) != 0);
      clr   = ($urandom_range(0, 30) == 0);
      ra    = 14'($urandom);
      rb    = 14'($urandom);
      cycle();
    end
    clr = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
